// File: rtl/vga_sync_decoder_if.sv
// Sync/colour inputs and recovered pixel outputs of the VGA sync decoder.
interface vga_sync_decoder_if;
    logic        h_sync;
    logic        v_sync;
    logic [3:0]  red_in;
    logic [3:0]  green_in;
    logic [3:0]  blue_in;
    logic [10:0] pxl_x;
    logic [10:0] pxl_y;
    logic        en;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        frame_start;
    logic        locked;
    logic        line_err;

    modport master (
        output h_sync, v_sync, red_in, green_in, blue_in,
        input  pxl_x, pxl_y, en, red, green, blue, frame_start, locked, line_err
    );

    modport slave (
        input  h_sync, v_sync, red_in, green_in, blue_in,
        output pxl_x, pxl_y, en, red, green, blue, frame_start, locked, line_err
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position, active-video enable and timing lock from raw VGA syncs.
// Latency: 2 clk_25 from input port to every output; no backpressure, one pixel per clock.
module vga_sync_decoder #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk_25,
    input  logic              reset,
    vga_sync_decoder_if.slave vga
);

    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic          L_ON      = (SYNC_POL != 0);
    localparam logic          L_OFF     = !L_ON;
    localparam logic [10:0]   L_H_START = 11'(H_START);
    localparam logic [10:0]   L_H_END   = 11'(H_START + WIDTH);
    localparam logic [10:0]   L_V_START = 11'(V_START);
    localparam logic [10:0]   L_V_END   = 11'(V_START + HEIGHT);
    localparam logic [11:0]   L_H_TOTAL = 12'(H_TOTAL);
    localparam logic [11:0]   L_V_TOTAL = 12'(V_TOTAL);
    localparam logic [GW-1:0] L_LOCK    = GW'(LOCK_FRAMES);
    localparam logic [10:0]   L_SAT     = 11'h7FF;

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic          r_hs, r_vs, r_hs_q, r_vs_q;
    logic [3:0]    r_red_s, r_grn_s, r_blu_s;
    logic [10:0]   r_h_cnt, r_v_cnt;
    logic [1:0]    r_state;
    logic [GW-1:0] r_good_cnt;
    logic          r_frame_err;
    logic          r_h_seen;

    logic [10:0]   r_pxl_x, r_pxl_y;
    logic          r_en, r_fs, r_lerr;
    logic [3:0]    r_red, r_grn, r_blu;

    logic          w_hs_edge, w_vs_edge;
    logic [10:0]   w_h_inc, w_v_inc, w_h_pos, w_v_pos;
    logic          w_h_sat, w_line_err, w_lines_ok;
    logic [GW-1:0] w_good_inc;
    logic [1:0]    w_state_nxt;
    logic [GW-1:0] w_good_nxt;
    logic          w_ferr_nxt, w_seen_nxt;
    logic          w_en;

    // Sample stage plus one-deep history for edge detection.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_hs    <= L_OFF;
            r_vs    <= L_OFF;
            r_hs_q  <= L_OFF;
            r_vs_q  <= L_OFF;
            r_red_s <= '0;
            r_grn_s <= '0;
            r_blu_s <= '0;
        end else begin
            r_hs    <= vga.h_sync;
            r_vs    <= vga.v_sync;
            r_hs_q  <= r_hs;
            r_vs_q  <= r_vs;
            r_red_s <= vga.red_in;
            r_grn_s <= vga.green_in;
            r_blu_s <= vga.blue_in;
        end
    end

    assign w_hs_edge = (r_hs == L_ON) && (r_hs_q != L_ON);
    assign w_vs_edge = (r_vs == L_ON) && (r_vs_q != L_ON);

    // w_h_pos/w_v_pos are the position of the sample currently in the sample stage.
    assign w_h_inc    = (r_h_cnt == L_SAT) ? r_h_cnt : r_h_cnt + 11'd1;
    assign w_v_inc    = (r_v_cnt == L_SAT) ? r_v_cnt : r_v_cnt + 11'd1;
    assign w_h_pos    = w_hs_edge ? 11'd0 : w_h_inc;
    assign w_v_pos    = w_vs_edge ? 11'd0 : (w_hs_edge ? w_v_inc : r_v_cnt);
    assign w_h_sat    = (w_h_pos == L_SAT);
    assign w_line_err = w_hs_edge && r_h_seen && (({1'b0, r_h_cnt} + 12'd1) != L_H_TOTAL);
    assign w_lines_ok = (({1'b0, r_v_cnt} + 12'd1) == L_V_TOTAL);
    assign w_good_inc = r_good_cnt + GW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_ferr_nxt  = r_frame_err | w_line_err;
        w_seen_nxt  = r_h_seen | w_hs_edge;
        if (w_vs_edge) begin
            w_ferr_nxt = 1'b0;
        end
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_edge) begin
                    w_state_nxt = ST_MEASURE;
                    w_good_nxt  = '0;
                end
            end
            ST_MEASURE: begin
                if (w_vs_edge) begin
                    if (w_lines_ok && !r_frame_err && !w_line_err) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == L_LOCK) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_line_err || (w_vs_edge && !w_lines_ok) || w_h_sat) begin
                    w_state_nxt = ST_SEARCH;
                    w_seen_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_seen_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_state     <= ST_SEARCH;
            r_good_cnt  <= '0;
            r_frame_err <= 1'b0;
            r_h_seen    <= 1'b0;
        end else begin
            r_h_cnt     <= w_h_pos;
            r_v_cnt     <= w_v_pos;
            r_state     <= w_state_nxt;
            r_good_cnt  <= w_good_nxt;
            r_frame_err <= w_ferr_nxt;
            r_h_seen    <= w_seen_nxt;
        end
    end

    // Gating on the next state blanks video in the same cycle lock is lost.
    assign w_en = (w_state_nxt == ST_LOCKED)
               && (w_h_pos >= L_H_START) && (w_h_pos < L_H_END)
               && (w_v_pos >= L_V_START) && (w_v_pos < L_V_END);

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_en    <= 1'b0;
            r_pxl_x <= '0;
            r_pxl_y <= '0;
            r_red   <= '0;
            r_grn   <= '0;
            r_blu   <= '0;
            r_fs    <= 1'b0;
            r_lerr  <= 1'b0;
        end else begin
            r_en    <= w_en;
            r_pxl_x <= w_en ? (w_h_pos - L_H_START) : 11'd0;
            r_pxl_y <= w_en ? (w_v_pos - L_V_START) : 11'd0;
            r_red   <= w_en ? r_red_s : 4'd0;
            r_grn   <= w_en ? r_grn_s : 4'd0;
            r_blu   <= w_en ? r_blu_s : 4'd0;
            r_fs    <= w_en && (w_h_pos == L_H_START) && (w_v_pos == L_V_START);
            r_lerr  <= w_line_err;
        end
    end

    assign vga.en          = r_en;
    assign vga.pxl_x       = r_pxl_x;
    assign vga.pxl_y       = r_pxl_y;
    assign vga.red         = r_red;
    assign vga.green       = r_grn;
    assign vga.blue        = r_blu;
    assign vga.frame_start = r_fs;
    assign vga.line_err    = r_lerr;
    assign vga.locked      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled 100x20 raster so many frames fit a short run.
module tb_vga_sync_decoder;

    localparam int WIDTH   = 64;
    localparam int HEIGHT  = 12;
    localparam int H_TOTAL = 100;
    localparam int V_TOTAL = 20;
    localparam int H_START = 20;
    localparam int V_START = 4;
    localparam int H_SYNC  = 12;
    localparam int V_SYNC  = 2;

    localparam int M_UNL = 0, M_LK = 1, M_NONE = 2;
    localparam int S_EN = 0, S_X = 1, S_Y = 2, S_RED = 3, S_FS = 4, S_LK = 5, S_LERR = 6, S_BLUE = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_decoder_if vif();

    vga_sync_decoder #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .H_START(H_START), .V_START(V_START), .SYNC_POL(0), .LOCK_FRAMES(2)
    ) dut (
        .clk_25(clk),
        .reset (rst),
        .vga   (vif)
    );

    typedef struct {
        int    due;
        string tag;
        int    sel;
        int    exp;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_pass = 0;
    int  n_lerr = 0;
    int  base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic exp_at(input int dly, input string tag, input int sel, input int v);
        sb_t e;
        e.due = cyc + dly;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    function automatic int obs_of(input int sel);
        case (sel)
            S_EN:    return int'(vif.en);
            S_X:     return int'(vif.pxl_x);
            S_Y:     return int'(vif.pxl_y);
            S_RED:   return int'(vif.red);
            S_FS:    return int'(vif.frame_start);
            S_LK:    return int'(vif.locked);
            S_LERR:  return int'(vif.line_err);
            S_BLUE:  return int'(vif.blue);
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            chk(mon_e.tag, obs_of(mon_e.sel), mon_e.exp);
        end
        if (vif.line_err === 1'b1) n_lerr++;
    end

    // flags[0]: line_err expected at this line's first edge; flags[1]: lock rises at this line.
    task automatic drive_line(input int ln, input int len, input bit vs, input int mode, input bit [1:0] flags);
        bit act_row;
        act_row = (ln >= V_START) && (ln < V_START + HEIGHT);
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            vif.h_sync   = (c < H_SYNC) ? 1'b0 : 1'b1;
            vif.v_sync   = vs ? 1'b0 : 1'b1;
            vif.red_in   = (ln == V_START && c == H_START) ? 4'hA : 4'($urandom);
            vif.green_in = 4'($urandom);
            vif.blue_in  = 4'($urandom);
            if (flags[1] && c == 0) begin
                exp_at(1, "lock_pre", S_LK, 0);
                exp_at(2, "lock_rise", S_LK, 1);
            end
            if (flags[0] && c == 0) begin
                exp_at(2, "lerr_pulse", S_LERR, 1);
                exp_at(2, "lock_fall_err", S_LK, 0);
            end
            if (flags[0] && c == 1) exp_at(2, "lerr_end", S_LERR, 0);
            if (mode == M_LK && act_row) begin
                if (c == H_START - 1) exp_at(2, "en_before", S_EN, 0);
                if (c == H_START) begin
                    exp_at(2, "en_first", S_EN, 1);
                    exp_at(2, "x_first", S_X, 0);
                    exp_at(2, "y_row", S_Y, ln - V_START);
                    exp_at(2, "red_first", S_RED, int'(vif.red_in));
                    exp_at(2, "fs_first", S_FS, int'(ln == V_START));
                end
                if (c == H_START + 1) begin
                    exp_at(2, "x_second", S_X, 1);
                    exp_at(2, "fs_second", S_FS, 0);
                end
                if (c == H_START + WIDTH - 1) begin
                    exp_at(2, "en_last", S_EN, 1);
                    exp_at(2, "x_last", S_X, WIDTH - 1);
                    exp_at(2, "blue_last", S_BLUE, int'(vif.blue_in));
                end
                if (c == H_START + WIDTH) begin
                    exp_at(2, "en_after", S_EN, 0);
                    exp_at(2, "x_after", S_X, 0);
                    exp_at(2, "red_after", S_RED, 0);
                end
            end
            if (mode == M_LK && (ln == V_START - 1 || ln == V_START + HEIGHT) && c == H_START) begin
                exp_at(2, "en_vblank", S_EN, 0);
                exp_at(2, "y_vblank", S_Y, 0);
            end
            if (mode == M_UNL && act_row && c == H_START) begin
                exp_at(2, "en_unlocked", S_EN, 0);
                exp_at(2, "lk_unlocked", S_LK, 0);
                exp_at(2, "x_unlocked", S_X, 0);
            end
            if (mode == M_LK && len > 2047) begin
                if (c == 2046) exp_at(2, "sat_lock_hold", S_LK, 1);
                if (c == 2047) begin
                    exp_at(2, "sat_lock_fall", S_LK, 0);
                    exp_at(2, "sat_en", S_EN, 0);
                end
            end
        end
    endtask

    task automatic drive_frame(input int nlines, input int mode, input bit rise,
                               input int odd_ln, input int odd_len);
        int  len;
        int  m;
        bit  err;
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == odd_ln) ? odd_len : H_TOTAL;
            m   = (mode == M_LK && odd_ln >= 0 && ln > odd_ln) ? M_UNL : mode;
            err = (mode == M_LK && odd_ln >= 0 && odd_len < H_TOTAL && ln == odd_ln + 1);
            drive_line(ln, len, ln < V_SYNC, m, {rise && ln == 0, err});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vif.h_sync   = 1'b1;
        vif.v_sync   = 1'b1;
        vif.red_in   = 4'd0;
        vif.green_in = 4'd0;
        vif.blue_in  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", int'(vif.en), 0);
        chk("rst_x", int'(vif.pxl_x), 0);
        chk("rst_y", int'(vif.pxl_y), 0);
        chk("rst_red", int'(vif.red), 0);
        chk("rst_fs", int'(vif.frame_start), 0);
        chk("rst_locked", int'(vif.locked), 0);
        chk("rst_lerr", int'(vif.line_err), 0);
        rst = 1'b0;

        // Acquisition from reset: lock at the third vsync edge.
        drive_frame(V_TOTAL, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL, M_LK, 1'b1, -1, 0);
        drive_frame(V_TOTAL, M_LK, 1'b0, -1, 0);
        chk("clean_lerr_cnt", n_lerr, 0);

        // One short line while locked.
        base = n_lerr;
        drive_frame(V_TOTAL, M_LK, 1'b0, 8, H_TOTAL - 1);
        drive_frame(V_TOTAL, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL, M_LK, 1'b1, -1, 0);
        chk("short_lerr_cnt", n_lerr, base + 1);

        // hsync missing long enough to saturate the line counter.
        base = n_lerr;
        drive_frame(V_TOTAL, M_LK, 1'b0, 5, 2100);
        drive_frame(V_TOTAL, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL, M_LK, 1'b1, -1, 0);
        chk("sat_lerr_cnt", n_lerr, base);

        // Reset mid-line during active video.
        for (int ln = 0; ln < 6; ln++) drive_line(ln, H_TOTAL, ln < V_SYNC, M_LK, 2'b00);
        drive_line(6, 41, 1'b0, M_NONE, 2'b00);
        chk("pre_rst_en", int'(vif.en), 1);
        chk("pre_rst_x", int'(vif.pxl_x), 18);
        rst = 1'b1;
        #1;
        chk("arst_en", int'(vif.en), 0);
        chk("arst_x", int'(vif.pxl_x), 0);
        chk("arst_y", int'(vif.pxl_y), 0);
        chk("arst_locked", int'(vif.locked), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = n_lerr;
        for (int ln = 7; ln < V_TOTAL; ln++) drive_line(ln, H_TOTAL, 1'b0, M_UNL, 2'b00);

        // Reacquire, with a 19-line frame while measuring.
        drive_frame(V_TOTAL, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL - 1, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL, M_UNL, 1'b0, -1, 0);
        drive_frame(V_TOTAL, M_LK, 1'b1, -1, 0);
        drive_frame(V_TOTAL, M_LK, 1'b0, -1, 0);
        chk("relock_lerr_cnt", n_lerr, base);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The module SHALL have these parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- H_TOTAL, 800, clocks per line.
- V_TOTAL, 525, lines per frame.
- H_START, 144, clocks from hsync leading edge to the first active pixel.
- V_START, 35, lines from vsync leading edge to the first active line.
- SYNC_POL, 0, asserted sync level (0 = active-low).
- LOCK_FRAMES, 2, consecutive good frames required for lock.
REQ-002 The module SHALL have these ports:
- clk_25  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- h_sync  in  1  incoming horizontal sync.
- v_sync  in  1  incoming vertical sync.
- red_in, green_in, blue_in  in  4 each  incoming colour.
- pxl_x  out  11  recovered column.
- pxl_y  out  11  recovered row.
- en  out  1  active pixel valid.
- red, green, blue  out  4 each  colour aligned with en.
- frame_start  out  1  one-cycle pulse at pixel (0,0).
- locked  out  1  timing lock.
- line_err  out  1  one-cycle pulse on a bad line length.

Function
REQ-003 h_sync, v_sync and the RGB inputs SHALL be registered once, giving the sample stage.
REQ-004 A sync leading edge SHALL be a transition, between consecutive samples, from not-asserted to the SYNC_POL level.
REQ-005 h_cnt (11 bits) SHALL load 0 on an hsync leading edge, increment otherwise, and saturate at 2047.
REQ-006 v_cnt (11 bits) SHALL load 0 on a vsync leading edge and increment on an hsync leading edge otherwise; the vsync edge SHALL win when both occur in the same cycle.
REQ-007 On each hsync leading edge, if h_cnt+1 differs from H_TOTAL and a previous edge was seen since reset or SEARCH entry, line_err SHALL pulse high for 1 cycle.
REQ-008 The FSM SHALL have states SEARCH, MEASURE and LOCKED, with reset state SEARCH.
REQ-009 SEARCH SHALL go to MEASURE on a vsync leading edge, with good_cnt=0.
REQ-010 In MEASURE, at each vsync leading edge:
- if lines counted equal V_TOTAL and no line_err occurred that frame, good_cnt SHALL increment;
- otherwise good_cnt SHALL clear and the FSM SHALL stay in MEASURE;
- when good_cnt reaches LOCK_FRAMES, the FSM SHALL enter LOCKED.
REQ-011 LOCKED SHALL go to SEARCH on any of:
- line_err;
- a vsync leading edge with a line count differing from V_TOTAL;
- h_cnt saturation.
REQ-012 locked SHALL be 1 exactly while the state is LOCKED.
REQ-013 en SHALL be 1 only when all of these hold:
- state is LOCKED;
- H_START <= h_cnt < H_START+WIDTH;
- V_START <= v_cnt < V_START+HEIGHT.
REQ-014 When en=1, pxl_x SHALL equal h_cnt-H_START and pxl_y SHALL equal v_cnt-V_START; when en=0, both SHALL be 0.
REQ-015 The red, green and blue outputs SHALL equal the sampled inputs when en=1 and 0 otherwise.
REQ-016 pxl_x, pxl_y, en, RGB, frame_start and line_err SHALL be registered, with a fixed latency of exactly 2 clk_25 cycles from an input being present at the port.
REQ-017 frame_start SHALL equal 1 in the same cycle as en=1 with pxl_x=0 and pxl_y=0.
REQ-018 Loss of lock SHALL force en=0 from the cycle after the SEARCH transition, including mid-line.
REQ-019 A vsync edge that arrives before any hsync edge SHALL still be counted as valid.

Reset
REQ-020 While reset=1, all of the following SHALL hold:
- state SEARCH;
- h_cnt, v_cnt and good_cnt equal 0;
- all outputs equal 0;
- sample registers hold the deasserted sync level.
REQ-021 Release of reset SHALL begin normal operation on the next clk_25 edge.
REQ-022 Assertion of reset mid-frame SHALL take effect immediately and asynchronously.

Verification
REQ-023 Apply 3 clean 800x525 frames (negative sync, 96/2-clock pulses) -> locked rises at the 3rd vsync leading edge+2 cycles, and line_err never pulses.
REQ-024 When locked, drive red_in=4'hA at line 35 clock 144 -> 2 cycles later: en=1, pxl_x=0, pxl_y=0, frame_start=1, red=4'hA.
REQ-025 When locked, drive one 799-clock line -> line_err pulses once, locked falls, en stays 0 until 2 further good frames.
REQ-026 Drive a frame of 524 lines in MEASURE -> good_cnt clears and locked stays 0 until 2 subsequent good frames.
REQ-027 Hold h_sync deasserted for 2100 cycles when locked -> locked falls after h_cnt reaches 2047, and en=0.
REQ-028 Assert reset mid-line with en=1 -> en, pxl_x, pxl_y and locked are 0 immediately, and reacquisition requires a fresh vsync edge.
